tick_burst_gen: RTL and testbench
=================================

Name: tick_burst_gen

Overview:
- Transmit-side counterpart of the tick counter: on a start request it emits a burst of exactly `count` single-cycle ticks, spaced `period+1` clocks apart, then pulses `done`.
- Drives the `tick` input of a tick counter (test stimulus, pulse trains to timers, LED/segment strobes).
- Its output `tick` is directly compatible with a per-clock-sampled tick counter, so a burst of `count` ticks advances such a counter by exactly `count`.

Parameters:
- N, 4, width of burst count and `remaining`.
- P, 8, width of the period field; tick spacing is period+1 clocks (1..2^P).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  burst request, sampled only in IDLE.
- count  in  N  number of ticks in the burst, latched on accepted start.
- period  in  P  tick spacing minus one, latched on accepted start.
- tick  out  1  registered single-cycle tick.
- busy  out  1  high while state is RUN.
- done  out  1  registered one-cycle pulse at burst end.
- remaining  out  N  ticks still to be emitted after the current cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE; tick=0, done=0, busy=0, remaining=0, phase=0, period_reg=0. All outputs come straight from registers.
- States:
  - IDLE: waits for start.
  - RUN: emitting ticks.
- IDLE, start=1, count!=0 at edge k:
  - period_reg<=period, phase<=period, remaining<=count-1, tick<=1, state<=RUN.
  - The first tick is therefore in the cycle after the start edge.
- IDLE, start=1, count==0: done<=1 for one cycle, no ticks, stays IDLE.
- RUN, phase!=0: phase<=phase-1, tick<=0.
- RUN, phase==0, remaining!=0: tick<=1, remaining<=remaining-1, phase<=period_reg.
- RUN, phase==0, remaining==0: tick<=0, done<=1, state<=IDLE.
- Timing, with cycle 0 = the start edge:
  - ticks fall in cycles 1, 1+(period+1), …, 1+(count-1)(period+1).
  - done falls in cycle count*(period+1)+1.
  - busy=1 from cycle 1 through the cycle before done.
- period==0: ticks in consecutive cycles (tick held high for `count` cycles); done follows one cycle after the last tick.
- count=2^N-1 and period=2^P-1 must work with no overflow; phase and remaining are down-counters only and never wrap.
- start while busy=1: ignored; count and period inputs are not re-sampled.
- start in the same cycle that done=1: accepted (state is already IDLE); the next burst begins and done drops.
- done and tick are never high in the same cycle.
- Reset asserted mid-burst: all registers clear immediately, with no done pulse; after release the block waits in IDLE.

Optional Feature:
- Macro TICK_BURST_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in RUN at an edge: state<=IDLE, tick<=0, done<=1; remaining holds its value, showing the ticks not sent.
  - abort has priority over a tick due on the same edge.
  - abort in IDLE has no effect.
- Undefined: no `abort` port; a burst always runs to completion.

Decomposition:
- Package tick_burst_pkg:
  - state enum (IDLE, RUN).
  - reset-value constants.
- One natural sub-module: tick_phase_timer.
  - P-bit loadable down-counter with load/enable and a zero flag.
  - Used for `phase`; FSM, remaining and outputs stay in tick_burst_gen.

Test Plan:
- Burst: reset release, start with count=5, period=2 at cycle 0 -> tick in cycles 1,4,7,10,13; done in cycle 16; busy in cycles 1-15; a downstream 4-bit tick counter reads 5.
- Back-to-back: period=0, count=3 -> tick in cycles 1-3, done in cycle 4; start in cycle 4 with count=2 -> ticks in cycles 5-6.
- Zero/ignore: count=0 -> done in cycle 1, no tick. start re-asserted with count=7 during a count=2 burst -> exactly 2 ticks.
- Max values: N=4, P=8, count=15, period=255 -> 15 ticks 256 apart; done at cycle 3841; remaining decrements 14..0.
- Reset mid-burst: reset=0 at cycle 5 of the count=5, period=2 burst -> tick, busy, done and remaining all 0 immediately (async); no done pulse afterward.
- TICK_BURST_ABORT_EN: abort at cycle 5 of the count=5, period=2 burst -> done in cycle 6, remaining=3, no further ticks. Without the macro, the port is absent and the full burst completes.

Source files
------------

// File: rtl/tick_burst_pkg.sv
// Shared types and reset values for the tick burst generator.
package tick_burst_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_TICK  = 1'b0;
  localparam logic   RST_DONE  = 1'b0;

endpackage

// File: rtl/tick_phase_timer.sv
// Loadable P-bit down-counter with a zero flag; times the gap between ticks.
module tick_phase_timer #(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [P-1:0] load_val,
  output logic [P-1:0] phase,
  output logic         zero
);

  localparam logic [P-1:0] ONE_P = {{(P-1){1'b0}}, 1'b1};

  logic [P-1:0] phase_q;
  logic [P-1:0] phase_d;

  // Load wins over enable; the counter parks at zero instead of wrapping.
  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = load_val;
    end else if (en && (phase_q != '0)) begin
      phase_d = phase_q - ONE_P;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
  assign zero  = (phase_q == '0);

endmodule

// File: rtl/tick_burst_gen.sv
// Emits `count` ticks spaced period+1 clocks apart, then pulses done.
// Optional abort input enabled by macro TICK_BURST_ABORT_EN.
module tick_burst_gen
  import tick_burst_pkg::*;
#(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] count,
  input  logic [P-1:0] period,
`ifdef TICK_BURST_ABORT_EN
  input  logic         abort,
`endif
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] remaining
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic [P-1:0] period_q, period_d;

  logic         phase_load;
  logic         phase_en;
  logic [P-1:0] phase_load_val;
  logic [P-1:0] phase_cnt;
  logic         phase_zero;

  tick_phase_timer #(.P(P)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (phase_load),
    .en       (phase_en),
    .load_val (phase_load_val),
    .phase    (phase_cnt),
    .zero     (phase_zero)
  );

  always_comb begin
    state_d        = state_q;
    tick_d         = 1'b0;
    done_d         = 1'b0;
    remaining_d    = remaining_q;
    period_d       = period_q;
    phase_load     = 1'b0;
    phase_en       = 1'b0;
    phase_load_val = period_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            // First tick goes out immediately; spacing restarts from period.
            period_d       = period;
            phase_load     = 1'b1;
            phase_load_val = period;
            remaining_d    = count - ONE_N;
            tick_d         = 1'b1;
            state_d        = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
`ifdef TICK_BURST_ABORT_EN
        if (abort) begin
          // remaining is left as-is so it reports the ticks never sent.
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else
`endif
        if (!phase_zero) begin
          phase_en = 1'b1;
        end else if (remaining_q != '0) begin
          tick_d      = 1'b1;
          remaining_d = remaining_q - ONE_N;
          phase_load  = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST_STATE;
      tick_q      <= RST_TICK;
      done_q      <= RST_DONE;
      remaining_q <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
    end
  end

  assign tick      = tick_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_RUN);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_tick_burst_gen.sv
// Directed bench for tick_burst_gen; abort steps run when TICK_BURST_ABORT_EN is defined.
module tb_tick_burst_gen;

  localparam int N = 4;
  localparam int P = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] count;
  logic [P-1:0] period;
`ifdef TICK_BURST_ABORT_EN
  logic         abort;
`endif
  logic         tick;
  logic         busy;
  logic         done;
  logic [N-1:0] remaining;

  int checks = 0;
  int errors = 0;
  logic [3:0] ds_cnt;

  tick_burst_gen #(.N(N), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .period    (period),
`ifdef TICK_BURST_ABORT_EN
    .abort     (abort),
`endif
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream per-clock tick counter fed by the generator.
  always @(posedge clk) begin
    if (!reset) ds_cnt <= 4'd0;
    else if (tick) ds_cnt <= ds_cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Inputs must already be set; the next edge is the start edge (cycle 0).
  // Checks cycles 1..min(stop_c, done cycle) and returns at that observation point.
  task automatic run_burst(input int cnt, input int per, input bit hold7, input int stop_c);
    int done_c;
    int last_c;
    logic exp_tick;
    int exp_rem;
    done_c = cnt * (per + 1) + 1;
    last_c = (stop_c < done_c) ? stop_c : done_c;
    @(posedge clk); #1;
    if (hold7) begin
      start = 1'b1;
      count = 4'd7;
    end else begin
      start = 1'b0;
    end
    for (int c = 1; c <= last_c; c++) begin
      exp_tick = (c < done_c) && (((c - 1) % (per + 1)) == 0);
      exp_rem  = (c < done_c) ? (cnt - 1 - (c - 1) / (per + 1)) : 0;
      chk($sformatf("tick c%0d n%0d p%0d", c, cnt, per), {31'd0, tick}, {31'd0, exp_tick});
      chk($sformatf("done c%0d n%0d p%0d", c, cnt, per), {31'd0, done}, {31'd0, (c == done_c)});
      chk($sformatf("busy c%0d n%0d p%0d", c, cnt, per), {31'd0, busy}, {31'd0, (c < done_c)});
      chk($sformatf("rem c%0d n%0d p%0d", c, cnt, per), {28'd0, remaining}, exp_rem);
      if (c < last_c) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s tick i%0d", tag, i), {31'd0, tick}, 32'd0);
      chk($sformatf("%s done i%0d", tag, i), {31'd0, done}, 32'd0);
      chk($sformatf("%s busy i%0d", tag, i), {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    count  = '0;
    period = '0;
`ifdef TICK_BURST_ABORT_EN
    abort  = 1'b0;
`endif
    #3;
    chk("rst tick", {31'd0, tick}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst rem", {28'd0, remaining}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_check(2, "post-rst");

    // count=5 period=2: ticks 1,4,7,10,13; done 16
    start = 1'b1; count = 4'd5; period = 8'd2;
    run_burst(5, 2, 1'b0, 100000);
    chk("downstream count", {28'd0, ds_cnt}, 32'd5);
    start = 1'b0;
    idle_check(2, "after-b1");
    $display("step burst5 done checks=%0d errors=%0d", checks, errors);

    // period=0 count=3, then a new start while done is high
    start = 1'b1; count = 4'd3; period = 8'd0;
    run_burst(3, 0, 1'b0, 100000);
    start = 1'b1; count = 4'd2; period = 8'd0;
    run_burst(2, 0, 1'b0, 100000);
    start = 1'b0;
    idle_check(2, "after-b2b");
    $display("step back-to-back done checks=%0d errors=%0d", checks, errors);

    // count=0: done in cycle 1 only
    start = 1'b1; count = 4'd0; period = 8'd4;
    run_burst(0, 4, 1'b0, 100000);
    start = 1'b0;
    idle_check(3, "after-zero");
    $display("step zero-count done checks=%0d errors=%0d", checks, errors);

    // start held with count=7 during a count=2 burst is ignored
    start = 1'b1; count = 4'd2; period = 8'd3;
    run_burst(2, 3, 1'b1, 100000);
    start = 1'b0;
    idle_check(10, "after-ignore");
    $display("step ignore-start done checks=%0d errors=%0d", checks, errors);

    // Maximum count and period: done at cycle 3841
    start = 1'b1; count = 4'd15; period = 8'd255;
    run_burst(15, 255, 1'b0, 100000);
    start = 1'b0;
    idle_check(2, "after-max");
    $display("step max done checks=%0d errors=%0d", checks, errors);

    // Asynchronous reset in cycle 5 of a count=5 period=2 burst
    start = 1'b1; count = 4'd5; period = 8'd2;
    run_burst(5, 2, 1'b0, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst tick", {31'd0, tick}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst rem", {28'd0, remaining}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_check(20, "after-midrst");
    $display("step mid-reset done checks=%0d errors=%0d", checks, errors);

`ifdef TICK_BURST_ABORT_EN
    // Abort sampled at edge 5: done in cycle 6 with remaining=3
    start = 1'b1; count = 4'd5; period = 8'd2;
    run_burst(5, 2, 1'b0, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort tick", {31'd0, tick}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd1);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort rem", {28'd0, remaining}, 32'd3);
    idle_check(12, "after-abort");
    chk("abort rem held", {28'd0, remaining}, 32'd3);
    // abort while idle does nothing
    abort = 1'b1;
    idle_check(2, "abort-idle");
    abort = 1'b0;
    $display("step abort done checks=%0d errors=%0d", checks, errors);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
